// File: rtl/component_pipe_reg.sv
// ---------------------------------------------------------------------------
// component_pipe_reg
//
// Purpose:
//   Parametrised multi-stage pipeline register with a valid/ready handshake
//   on each side. Words move forward into empty stages even while the output
//   is stalled, so bubbles collapse. Full throughput is one word per cycle.
//   Also provides a synchronous flush and a registered occupancy count.
//
// Parameters:
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1)
//   CNT_W  width of the occupancy count, $clog2(DEPTH+1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      synchronous clear of all stages
//   valid_in   upstream data valid
//   ready_in   block can accept d_in this cycle
//   d_in       upstream data
//   valid_out  output stage (DEPTH-1) holds data
//   ready_out  downstream accepts d_out this cycle
//   d_out      data of the output stage
//   count      number of valid stages, 0..DEPTH
//
// Optional feature (macro COMPONENT_PIPE_REG_DATA_RST_EN):
//   Defined   : data registers reset to zero and are zeroed by flush.
//   Undefined : data registers have no reset and ignore flush; d_out is
//               don't-care while valid_out is 0.
// ---------------------------------------------------------------------------
module component_pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [WIDTH-1:0] d_out,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] up_vld;
    logic [WIDTH-1:0] dat    [DEPTH];
    logic [WIDTH-1:0] up_dat [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // A stage may advance when it is empty or when its successor advances.
    // The output stage advances when empty or when downstream is ready.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = ~vld[DEPTH-1] | ready_out;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = ~vld[i] | adv[i+1];
        end
    end

    // Upstream source of each stage. Stage 0 uses the qualified input
    // transfer so that nothing enters while flush is asserted.
    always_comb begin
        up_vld[0] = in_xfer;
        up_dat[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            up_vld[i] = vld[i-1];
            up_dat[i] = dat[i-1];
        end
    end

    assign ready_in  = adv[0] & ~flush;
    assign in_xfer   = valid_in & ready_in;
    assign out_xfer  = vld[DEPTH-1] & ready_out;
    assign valid_out = vld[DEPTH-1];
    assign d_out     = dat[DEPTH-1];

    // Control state: valid bits and occupancy. Reset wins over flush, and
    // flush wins over transfers. An output transfer during flush is simply
    // consumed since the whole pipe empties anyway.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld   <= '0;
            count <= '0;
        end else if (flush) begin
            vld   <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    vld[i] <= up_vld[i];
                end
            end
            if (in_xfer && !out_xfer) begin
                count <= count + CNT_W'(1);
            end else if (out_xfer && !in_xfer) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef COMPONENT_PIPE_REG_DATA_RST_EN
    // Data registers with reset and flush clear. A stage loads only when a
    // valid word moves into it, so bubbles never toggle the datapath.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i] && up_vld[i]) begin
                    dat[i] <= up_dat[i];
                end
            end
        end
    end
`else
    // Data registers without reset. Loads are suppressed during flush so
    // the datapath is left exactly as it was; only the valid bits clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (adv[i] && up_vld[i] && !flush) begin
                dat[i] <= up_dat[i];
            end
        end
    end
`endif

endmodule

// File: doc/component_pipe_reg.md
Name: component_pipe_reg

Overview:
- Parametrised multi-stage pipeline register; successor to the single N-bit enabled flop.
- Carries WIDTH-bit data through DEPTH stages with a valid/ready handshake per side.
- Collapses bubbles, supports stall back-pressure and synchronous flush, and reports occupancy.
- Used to retime long datapaths between blocks without losing throughput.

Parameters:
- WIDTH, 8: data width in bits, >= 1.
- DEPTH, 2: number of register stages, >= 1.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- flush  input  1  synchronous clear of all stages.
- valid_in  input  1  upstream data valid.
- ready_in  output  1  block can accept d_in this cycle.
- d_in  input  WIDTH  upstream data.
- valid_out  output  1  stage DEPTH-1 holds data.
- ready_out  input  1  downstream accepts d_out this cycle.
- d_out  output  WIDTH  data of stage DEPTH-1.
- count  output  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- State per stage i (0..DEPTH-1): one valid bit vld[i] and one data register dat[i]. Stage 0 is the input stage; stage DEPTH-1 is the output stage.
- Advance rule:
  - adv[DEPTH-1] = ~vld[DEPTH-1] | ready_out.
  - adv[i] = ~vld[i] | adv[i+1].
  - Evaluation is combinational, from the output stage back to the input stage.
- Stage load, when adv[i] is 1:
  - vld[i] takes the upstream valid (valid_in for stage 0, vld[i-1] for others).
  - dat[i] takes the upstream data.
  - When adv[i] is 0, the stage holds.
- Data gating:
  - dat[i] loads only when the incoming valid is 1.
  - A bubble moving into a stage updates vld only and does not toggle data.
- Handshakes:
  - ready_in = adv[0] & ~flush.
  - An input transfer happens when valid_in & ready_in.
  - An output transfer happens when valid_out & ready_out.
  - ready_in may depend combinationally on ready_out.
  - valid_out and d_out depend only on registers.
  - Once valid_out is 1, valid_out and d_out stay stable until the output transfer.
- Latency and throughput:
  - Empty pipe with ready_out held at 1: data accepted in cycle N appears on d_out in cycle N+DEPTH.
  - Sustained throughput is 1 word per cycle.
  - No word is ever dropped or duplicated.
- Stall: with ready_out = 0, words pack forward into empty stages. ready_in falls only when all DEPTH stages are valid.
- Full with simultaneous events: when full and ready_out = 1, an output transfer and an input transfer occur in the same cycle, and count is unchanged.
- count:
  - Registered.
  - Increments on input-only, decrements on output-only, holds on both or neither.
  - Always equals the popcount of vld.
  - Never exceeds DEPTH and never underflows.
- flush:
  - All vld cleared and count = 0 on the next edge.
  - Any output transfer in the flush cycle still counts as consumed.
  - No input is accepted in the flush cycle.
  - Data registers are untouched unless the optional feature is enabled.
- Reset:
  - rst_n = 0 at a clock edge clears all vld and count to 0, so valid_out = 0 and count = 0.
  - ready_in = 1 after reset, unless flush is asserted.
  - d_out: see Optional Feature.
  - Reset mid-operation discards all in-flight words.
  - Reset has priority over flush and over all transfers.

Optional Feature:
- Macro: COMPONENT_PIPE_REG_DATA_RST_EN.
- Defined:
  - Every dat[i] resets to {WIDTH{1'b0}} on rst_n = 0 and is cleared to 0 on flush.
  - d_out = 0 after reset or flush.
- Not defined:
  - Data registers have no reset and are not affected by flush (smaller, lower-power datapath).
  - d_out is don't-care whenever valid_out = 0.
  - Control behaviour is identical in both builds.

Test Plan (WIDTH=8, DEPTH=3):
- Streaming: ready_out = 1; send 0x01..0x10 back-to-back from cycle 0. Expect 0x01 on d_out with valid_out = 1 at cycle 3, one word per cycle, order preserved, count steady at 3.
- Fill under stall: ready_out = 0; send 0xA0, 0xA1, 0xA2, 0xA3. Expect ready_in = 0 after 3 accepts, 0xA3 held off, count = 3. Raise ready_out: expect 0xA0, 0xA1, 0xA2, 0xA3 out with no gaps.
- Bubble collapse: send 0x11, idle 2 cycles, send 0x22, all with ready_out = 0. Expect count = 2, ready_in = 1, and 0x11 and 0x22 in stages 2 and 1.
- Full with simultaneous transfers: pipe full of 0x30..0x32, ready_out = 1 and valid_in = 1 with 0x33 in the same cycle. Expect 0x30 out, 0x33 accepted, count stays 3.
- Flush: pipe holding 0x40, 0x41 with ready_out = 0; assert flush for 1 cycle while offering 0x42. Expect ready_in = 0 that cycle, valid_out = 0 and count = 0 next cycle, and 0x42 never emitted. With COMPONENT_PIPE_REG_DATA_RST_EN defined, d_out = 0x00.
- Reset mid-operation: drive rst_n = 0 for 1 cycle with 2 words in flight. Expect valid_out = 0, count = 0, ready_in = 1 after the edge, and no stale word emitted afterwards.
